// File: rtl/sq_gen_pkg.sv
// Shared widths, state encoding and the low/high phase split for the square-wave generator.
package sq_gen_pkg;

    localparam int PERIOD_W   = 18;
    localparam int CNT_W      = 16;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    typedef struct packed {
        logic [PERIOD_W-1:0] low_len;
        logic [PERIOD_W-1:0] high_len;
    } split_t;

    // Odd periods give the extra cycle to the low phase.
    function automatic split_t phase_split(input logic [PERIOD_W-1:0] period);
        split_t s;
        s.high_len = period >> 1;
        s.low_len  = period - s.high_len;
        return s;
    endfunction

endpackage

// File: rtl/square_wave_gen_if.sv
// Configuration handshake between a controller (master) and the square-wave generator (slave).
interface square_wave_gen_if;
    import sq_gen_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [PERIOD_W-1:0] cfg_period;
    logic [CNT_W-1:0]    cfg_cycles;
    logic                cfg_err;

    modport master (output cfg_valid, cfg_period, cfg_cycles,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_period, cfg_cycles,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/sq_phase_timer.sv
// Loadable phase down-counter; expire is high while the count sits at zero.
module sq_phase_timer
    import sq_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    output logic [PERIOD_W-1:0] cnt,
    output logic                expire
);
    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt    = cnt_q;
    assign expire = (cnt_q == '0);
endmodule

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator: burst or continuous, period changes only at period boundaries.
// state | meaning
// IDLE  | output low, waiting for a legal configuration
// LOW   | low phase of the current period
// HIGH  | high phase; its expiry is the period boundary
module square_wave_gen
    import sq_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    square_wave_gen_if.slave  cfg,
    input  logic              stop,
    output logic              signal_out,
    output logic              cycle_done,
    output logic              busy
);
    state_e              state_q, state_d;
    logic                signal_q, signal_d;
    logic                cycle_done_q, cycle_done_d;
    logic                busy_q, busy_d;
    logic                cfg_err_q, cfg_err_d;
    logic                stop_req_q, stop_req_d;
    logic                pend_valid_q, pend_valid_d;
    logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
    logic [CNT_W-1:0]    pend_cycles_q, pend_cycles_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

    logic                tmr_load;
    logic [PERIOD_W-1:0] tmr_val;
    logic [PERIOD_W-1:0] tmr_cnt;
    logic                tmr_expire;

    logic                accept, legal;
    logic [CNT_W-1:0]    done_inc;

    sq_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (tmr_cnt),
        .expire   (tmr_expire)
    );

    assign accept   = cfg.cfg_valid & ~pend_valid_q;
    assign legal    = (cfg.cfg_period >= PERIOD_W'(MIN_PERIOD));
    assign done_inc = (&done_cnt_q) ? done_cnt_q : done_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        signal_d      = signal_q;
        cycle_done_d  = 1'b0;
        busy_d        = busy_q;
        cfg_err_d     = accept & ~legal;
        stop_req_d    = stop_req_q;
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_cycles_d = pend_cycles_q;
        period_d      = period_q;
        cycles_d      = cycles_q;
        done_cnt_d    = done_cnt_q;
        tmr_load      = 1'b0;
        tmr_val       = '0;

        if (state_q != IDLE) begin
            if (stop) stop_req_d = 1'b1;
            if (accept && legal) begin
                pend_valid_d  = 1'b1;
                pend_period_d = cfg.cfg_period;
                pend_cycles_d = cfg.cfg_cycles;
            end
        end

        case (state_q)
            IDLE: begin
                signal_d = 1'b0;
                if (accept && legal) begin
                    state_d    = LOW;
                    busy_d     = 1'b1;
                    stop_req_d = 1'b0;
                    period_d   = cfg.cfg_period;
                    cycles_d   = cfg.cfg_cycles;
                    done_cnt_d = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = phase_split(cfg.cfg_period).low_len - PERIOD_W'(1);
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    state_d  = HIGH;
                    signal_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = phase_split(period_q).high_len - PERIOD_W'(1);
                    // a one-cycle high phase is itself the last HIGH cycle
                    if (phase_split(period_q).high_len == PERIOD_W'(1)) cycle_done_d = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_cnt == PERIOD_W'(1)) cycle_done_d = 1'b1;
                if (tmr_expire) begin
                    signal_d = 1'b0;
                    if (stop_req_q || stop) begin
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                        stop_req_d   = 1'b0;
                        pend_valid_d = 1'b0;
                    end else if (cycles_q != '0 && done_inc == cycles_q) begin
                        // pending work is dropped so IDLE always reports a free slot
                        state_d      = IDLE;
                        busy_d       = 1'b0;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid_q) begin
                        state_d      = LOW;
                        pend_valid_d = 1'b0;
                        period_d     = pend_period_q;
                        cycles_d     = pend_cycles_q;
                        done_cnt_d   = '0;
                        tmr_load     = 1'b1;
                        tmr_val      = phase_split(pend_period_q).low_len - PERIOD_W'(1);
                    end else begin
                        state_d    = LOW;
                        done_cnt_d = done_inc;
                        tmr_load   = 1'b1;
                        tmr_val    = phase_split(period_q).low_len - PERIOD_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                signal_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            signal_q      <= 1'b0;
            cycle_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            stop_req_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_cycles_q <= '0;
            period_q      <= '0;
            cycles_q      <= '0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            signal_q      <= signal_d;
            cycle_done_q  <= cycle_done_d;
            busy_q        <= busy_d;
            cfg_err_q     <= cfg_err_d;
            stop_req_q    <= stop_req_d;
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            pend_cycles_q <= pend_cycles_d;
            period_q      <= period_d;
            cycles_q      <= cycles_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    assign signal_out    = signal_q;
    assign cycle_done    = cycle_done_q;
    assign busy          = busy_q;
    assign cfg.cfg_ready = ~pend_valid_q;
    assign cfg.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_square_wave_gen.sv
// Scoreboard bench: each scenario pushes the per-cycle expected waveform, a monitor pops and compares.
module tb_square_wave_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop = 1'b0;
    logic signal_out, cycle_done, busy;

    square_wave_gen_if cfg_if();

    square_wave_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cfg        (cfg_if),
        .stop       (stop),
        .signal_out (signal_out),
        .cycle_done (cycle_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sig;
        logic done;
        logic bsy;
        logic rdy;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   elapsed  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: observed %0h required %0h", tag, $time, got, exp);
        end
    endtask

    // packed order {sig,done,busy,ready,err} matches the observed vector below
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("wave{sig,done,busy,rdy,err}",
                  32'({signal_out, cycle_done, busy, cfg_if.cfg_ready, cfg_if.cfg_err}),
                  32'(e));
        end
    end

    task automatic push_seg(input logic s, input logic d, input logic b,
                            input logic r, input logic e, input int n);
        exp_t x;
        x = '{sig: s, done: d, bsy: b, rdy: r, err: e};
        for (int i = 0; i < n; i++) exp_q.push_back(x);
    endtask

    task automatic push_period(input int p);
        int lo, hi;
        hi = p / 2;
        lo = p - hi;
        push_seg(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, lo);
        if (hi > 1) push_seg(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, hi - 1);
        push_seg(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
    endtask

    task automatic push_idle(input int n);
        push_seg(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n);
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
        elapsed += k;
    endtask

    task automatic finish_to(input int n);
        if (n > elapsed) tick(n - elapsed);
        elapsed = 0;
    endtask

    task automatic cfg_send(input int p, input int c, input logic with_stop);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = 18'(p);
        cfg_if.cfg_cycles = 16'(c);
        stop              = with_stop;
        tick(1);
        cfg_if.cfg_valid  = 1'b0;
        stop              = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_cycles = '0;

        // reset state observed while rst is held
        repeat (3) @(negedge clk);
        push_idle(2);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // P=40, 20-period burst
        elapsed = 0;
        for (int i = 0; i < 20; i++) push_period(40);
        push_idle(1);
        cfg_send(40, 20, 1'b0);
        finish_to(801);

        // P=3 x4, then P=2 x3
        for (int i = 0; i < 4; i++) push_period(3);
        push_idle(1);
        cfg_send(3, 4, 1'b0);
        finish_to(13);
        for (int i = 0; i < 3; i++) push_period(2);
        push_idle(1);
        cfg_send(2, 3, 1'b0);
        finish_to(7);

        // illegal periods are rejected with a single cfg_err pulse
        push_seg(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        push_idle(2);
        cfg_send(1, 5, 1'b0);
        finish_to(3);
        push_seg(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        push_idle(2);
        cfg_send(0, 0, 1'b0);
        finish_to(3);

        // continuous P=1040, retune to P=120 mid-HIGH of period 4, then stop+cfg mid-LOW
        for (int i = 0; i < 3; i++) push_period(1040);
        push_seg(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 520);
        push_seg(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 100);
        push_seg(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 419);
        push_seg(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 3; i++) push_period(120);
        push_seg(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10);
        push_seg(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 50);
        push_seg(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 59);
        push_seg(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        push_idle(3);
        cfg_send(1040, 0, 1'b0);
        tick(3740 - elapsed);
        cfg_send(120, 0, 1'b0);
        tick(4530 - elapsed);
        cfg_send(40, 5, 1'b1);
        finish_to(4643);

        // reset mid-HIGH of P=520 aborts without cycle_done
        push_seg(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 260);
        push_seg(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 40);
        push_idle(4);
        cfg_send(520, 0, 1'b0);
        tick(300 - elapsed);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        finish_to(304);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/square_wave_gen.md
Name: square_wave_gen

Overview:
- Programmable square-wave generator: produces a single-bit square wave of a configured period (in clk cycles), either for a finite burst or continuously.
- Transmit-side counterpart of freq_detector_square. It provides stimulus for the period/stable measurement path and a test-tone source on the board.
- The configured period is measured by the detector as the same value in clk cycles.
- Period changes take effect only at period boundaries, so the output never glitches.

Parameters:
- PERIOD_W, 18, width of the period in clk cycles. Matches the detector's period output width.
- CNT_W, 16, width of the burst cycle count.
- MIN_PERIOD, 2, smallest legal period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration slot free
- cfg_period  in  PERIOD_W  full period in clk cycles
- cfg_cycles  in  CNT_W  number of periods in the burst; 0 = continuous
- stop  in  1  graceful stop request (single-cycle pulse)
- signal_out  out  1  registered square wave
- cycle_done  out  1  one-clk pulse at the end of each completed period
- busy  out  1  high while generating
- cfg_err  out  1  one-clk pulse when a configuration is rejected

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Next state: state=IDLE, signal_out=0, cycle_done=0, busy=0, cfg_err=0, cfg_ready=1.
  - Pending config and stop request are cleared.
  - Reset mid-period aborts immediately; no cycle_done is produced.
- Period split:
  - low phase = P - floor(P/2) cycles; high phase = floor(P/2) cycles.
  - Each period starts with the low phase.
  - Odd P gives the extra cycle to the low phase. Example: P=3 gives 2 low, 1 high.
- Handshake:
  - A transfer occurs on cfg_valid & cfg_ready at a clk edge.
  - cfg_ready = ~pending_valid.
  - If cfg_period < MIN_PERIOD: the transfer completes, cfg_err pulses on the next cycle, and no other state changes.
- States:
  - IDLE -> LOW: on an accepted legal config, the period and count are loaded.
    - signal_out=0 and busy=1 from the following edge.
    - First rising edge of signal_out occurs ceil(P/2) cycles after entering LOW.
  - LOW -> HIGH: when the phase counter expires. signal_out=1.
  - HIGH -> LOW/IDLE: when the high phase expires (period boundary).
    - cycle_done pulses during the last HIGH cycle, aligned with the edge where signal_out falls.
- Period-boundary priority, highest first:
  - (a) stop_req latched: go to IDLE, discard any pending config.
  - (b) burst count reached (cfg_cycles != 0 and done count == cfg_cycles): go to IDLE.
  - (c) pending config: load the new period and count, clear the done count, go to LOW.
  - (d) otherwise: go to LOW, increment the done count.
- Config during LOW/HIGH:
  - Stored as pending; cfg_ready drops until the pending config is applied at the boundary.
  - A second request waits.
  - A config accepted in the same cycle as the boundary is applied at the next boundary.
- stop:
  - Ignored in IDLE.
  - While running, it is latched and the current period always completes.
  - stop and cfg accepted in the same cycle: stop wins, and the cfg is dropped at the boundary.
- IDLE outputs: signal_out=0, busy=0.
- Arithmetic:
  - Phase counter is PERIOD_W wide, a down-counter loaded with phase length - 1.
  - Done count is CNT_W wide, saturating; no wrap in continuous mode.

Decomposition:
- Package sq_gen_pkg:
  - state enum {IDLE, LOW, HIGH}
  - PERIOD_W, CNT_W, MIN_PERIOD localparams
  - function for the low/high split
- One natural sub-module, sq_phase_timer:
  - Loadable down-counter with an expire flag.
  - Instantiated once, reloaded at each phase change.
- FSM, pending register and burst counter stay in square_wave_gen.

Test Plan:
- cfg P=40, cycles=20 -> signal_out 20 low/20 high repeated 20 times; 20 cycle_done pulses 40 clk apart; busy falls after the 20th, signal_out=0.
- cfg P=3, cycles=4 -> pattern 0,0,1 x4; cycle_done every 3 clk; P=2 -> 0,1 alternating.
- cfg P=1 (and P=0) -> cfg_err pulse for 1 clk, busy stays 0, signal_out stays 0.
- P=1040 continuous; after ~3 periods issue cfg P=120 mid-HIGH -> cfg_ready low until the boundary, current 1040 period completes intact, then 60/60 periods.
- Continuous P=120, pulse stop mid-LOW together with cfg_valid P=40 -> current period finishes, cycle_done pulses, IDLE; P=40 never appears; cfg_ready back to 1.
- rst asserted mid-HIGH of P=520 -> next edge signal_out=0, busy=0, no cycle_done.
- Loopback into freq_detector_square with P=1040 continuous -> detector reports period 1040 with stable asserted.
